// File: rtl/keypad_entry_pkg.sv
// Shared constants for the keypad entry sequencer: FSM state encoding and command key codes.
// The optional idle auto-clear is enabled by defining ENTRY_TIMEOUT_EN.
package keypad_entry_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ENTRY = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_BKSP  = 4'hB;
  localparam logic [3:0] KEY_CLR   = 4'hC;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'd9;
  endfunction

endpackage

// File: rtl/keypad_digit_buffer.sv
// BCD shift register holding the digits typed so far; newest digit lands in [3:0].
// Clear beats push, push beats pop; push when full and pop when empty are ignored.
module keypad_digit_buffer #(
  parameter int NUM_DIGITS = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              push,
  input  logic                              pop,
  input  logic                              clr,
  input  logic [3:0]                        digit,
  output logic [4*NUM_DIGITS-1:0]           bcd,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   count,
  output logic                              full,
  output logic                              empty
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);

  assign full  = (count == CW'(NUM_DIGITS));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      bcd   <= '0;
      count <= '0;
    end else if (push && !full) begin
      bcd   <= (bcd << 4) | W'(digit);
      count <= count + CW'(1);
    end else if (pop && !empty) begin
      bcd   <= bcd >> 4;
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry sequencer: builds a BCD number from key strobes and commits it over valid/ready.
// Define ENTRY_TIMEOUT_EN to auto-clear an entry left idle for TIMEOUT_CYCLES cycles.
module keypad_entry_ctrl
  import keypad_entry_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              KEY_STROBE,
  input  logic [3:0]                        KEY_CODE,
  input  logic                              VALUE_READY,
  output logic                              VALUE_VALID,
  output logic [4*NUM_DIGITS-1:0]           VALUE_OUT,
  output logic [4*NUM_DIGITS-1:0]           DISPLAY_BCD,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   DIGIT_COUNT,
  output logic                              KEY_BUSY,
  output logic                              OVF_ERR,
  output logic                              TIMEOUT,
  output logic [1:0]                        STATE_DBG
);

  localparam int CW = $clog2(NUM_DIGITS + 1);

  // Handshake: VALUE_OUT is offered while VALUE_VALID=1 and must not change until an
  // edge sees VALUE_VALID & VALUE_READY; that edge completes the transfer.

  logic [1:0] state, state_n;
  logic       accept, key_digit, buf_push, buf_pop, buf_clr;
  logic       buf_full, buf_empty, handshake, tmo_fire;

  assign accept    = KEY_STROBE && (state != S_HOLD);
  assign key_digit = is_digit(KEY_CODE);
  assign handshake = (state == S_HOLD) && VALUE_READY;

  assign buf_push = accept && key_digit;
  assign buf_pop  = accept && (KEY_CODE == KEY_BKSP) && !buf_empty;
  assign buf_clr  = (accept && (KEY_CODE == KEY_CLR)) || handshake || tmo_fire;

  keypad_digit_buffer #(.NUM_DIGITS(NUM_DIGITS)) u_buffer (
    .clk   (CLK),
    .rst_n (RESET),
    .push  (buf_push),
    .pop   (buf_pop),
    .clr   (buf_clr),
    .digit (KEY_CODE),
    .bcd   (DISPLAY_BCD),
    .count (DIGIT_COUNT),
    .full  (buf_full),
    .empty (buf_empty)
  );

`ifdef ENTRY_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] idle_cnt;

  // Any strobe, accepted or ignored, counts as activity and beats the timeout.
  assign tmo_fire = (state == S_ENTRY) && !KEY_STROBE && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (!RESET || (state != S_ENTRY) || KEY_STROBE || tmo_fire) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end
`else
  // Keeps TIMEOUT_CYCLES referenced so both builds share one parameter list.
  assign tmo_fire = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (accept && key_digit) state_n = S_ENTRY;
      end
      S_ENTRY: begin
        if (accept) begin
          if (KEY_CODE == KEY_ENTER) state_n = S_HOLD;
          else if (KEY_CODE == KEY_CLR) state_n = S_IDLE;
          else if ((KEY_CODE == KEY_BKSP) && (DIGIT_COUNT == CW'(1))) state_n = S_IDLE;
        end else if (tmo_fire) begin
          state_n = S_IDLE;
        end
      end
      S_HOLD: begin
        if (VALUE_READY) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state       <= S_IDLE;
      VALUE_VALID <= 1'b0;
      VALUE_OUT   <= '0;
      OVF_ERR     <= 1'b0;
      TIMEOUT     <= 1'b0;
    end else begin
      state   <= state_n;
      OVF_ERR <= accept && key_digit && (state == S_ENTRY) && buf_full;
      TIMEOUT <= tmo_fire;
      if (accept && (state == S_ENTRY) && (KEY_CODE == KEY_ENTER)) begin
        VALUE_OUT   <= DISPLAY_BCD;
        VALUE_VALID <= 1'b1;
      end else if (handshake) begin
        VALUE_VALID <= 1'b0;
      end
    end
  end

  assign KEY_BUSY  = (state == S_HOLD);
  assign STATE_DBG = state;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: directed vector table, hold/timeout sequences, random run vs. model.
// Timeout sequences are compiled in when ENTRY_TIMEOUT_EN is defined.
module tb_keypad_entry_ctrl;

  localparam int N  = 4;
  localparam int W  = 4 * N;
  localparam int CW = 3;
  localparam int T  = 16;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          KEY_STROBE = 1'b0;
  logic [3:0]    KEY_CODE = 4'h0;
  logic          VALUE_READY = 1'b0;
  logic          VALUE_VALID;
  logic [W-1:0]  VALUE_OUT;
  logic [W-1:0]  DISPLAY_BCD;
  logic [CW-1:0] DIGIT_COUNT;
  logic          KEY_BUSY;
  logic          OVF_ERR;
  logic          TIMEOUT;
  logic [1:0]    STATE_DBG;

  keypad_entry_ctrl #(.NUM_DIGITS(N), .TIMEOUT_CYCLES(T)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .KEY_STROBE  (KEY_STROBE),
    .KEY_CODE    (KEY_CODE),
    .VALUE_READY (VALUE_READY),
    .VALUE_VALID (VALUE_VALID),
    .VALUE_OUT   (VALUE_OUT),
    .DISPLAY_BCD (DISPLAY_BCD),
    .DIGIT_COUNT (DIGIT_COUNT),
    .KEY_BUSY    (KEY_BUSY),
    .OVF_ERR     (OVF_ERR),
    .TIMEOUT     (TIMEOUT),
    .STATE_DBG   (STATE_DBG)
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before 500000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard / counters ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Entered digits kept as a list, oldest first; the display value is derived arithmetically.
  int           m_dig[$];
  bit           m_hold;
  bit           m_ovf;
  bit           m_to;
  logic [W-1:0] m_value;
  int           m_idle;

  function automatic logic [W-1:0] m_disp();
    int v = 0;
    foreach (m_dig[i]) v = v * 16 + m_dig[i];
    return W'(v);
  endfunction

  task automatic model_edge(input bit rst, input bit stb, input logic [3:0] key, input bit rdy);
    if (!rst) begin
      m_dig.delete();
      m_hold = 0; m_ovf = 0; m_to = 0; m_value = '0; m_idle = 0;
      exp_q.delete();
      return;
    end
    m_ovf = 0;
    m_to  = 0;
    if (m_hold) begin
      if (rdy) begin
        m_hold = 0;
        m_dig.delete();
      end
      m_idle = 0;
    end else if (stb) begin
      m_idle = 0;
      if (key <= 4'd9) begin
        if (m_dig.size() < N) m_dig.push_back(int'(key));
        else m_ovf = 1;
      end else if (key == 4'hA) begin
        if (m_dig.size() > 0) begin
          m_value = m_disp();
          m_hold  = 1;
          exp_q.push_back(m_value);
        end
      end else if (key == 4'hB) begin
        if (m_dig.size() > 0) void'(m_dig.pop_back());
      end else if (key == 4'hC) begin
        m_dig.delete();
      end
    end else if (m_dig.size() > 0) begin
`ifdef ENTRY_TIMEOUT_EN
      m_idle++;
      if (m_idle == T) begin
        m_dig.delete();
        m_to   = 1;
        m_idle = 0;
      end
`endif
    end else begin
      m_idle = 0;
    end
  endtask

  task automatic check_model();
    logic [1:0] st;
    st = m_hold ? 2'd2 : ((m_dig.size() > 0) ? 2'd1 : 2'd0);
    chk("m_display", 32'(DISPLAY_BCD), 32'(m_disp()));
    chk("m_count",   32'(DIGIT_COUNT), 32'(m_dig.size()));
    chk("m_valid",   32'(VALUE_VALID), 32'(m_hold));
    chk("m_value",   32'(VALUE_OUT),   32'(m_value));
    chk("m_busy",    32'(KEY_BUSY),    32'(m_hold));
    chk("m_ovf",     32'(OVF_ERR),     32'(m_ovf));
    chk("m_timeout", 32'(TIMEOUT),     32'(m_to));
    chk("m_state",   32'(STATE_DBG),   32'(st));
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit rst, input bit stb, input logic [3:0] key, input bit rdy);
    @(negedge CLK);
    RESET = rst; KEY_STROBE = stb; KEY_CODE = key; VALUE_READY = rdy;
    if (rst && VALUE_VALID && rdy) begin
      if (exp_q.size() == 0) chk("sb_unexpected_value", 32'(VALUE_OUT), 32'hFFFF_FFFF);
      else chk("sb_value", 32'(VALUE_OUT), 32'(exp_q.pop_front()));
    end
    @(posedge CLK);
    #1;
    model_edge(rst, stb, key, rdy);
    check_model();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit            rst;
    bit            stb;
    logic [3:0]    key;
    bit            rdy;
    logic [W-1:0]  disp;
    logic [CW-1:0] cnt;
    bit            valid;
    logic [W-1:0]  vout;
    bit            busy;
    bit            ovf;
  } vec_t;

  vec_t tv[$];

  task automatic add(input bit rst, input bit stb, input logic [3:0] key, input bit rdy,
                     input logic [W-1:0] disp, input logic [CW-1:0] cnt, input bit valid,
                     input logic [W-1:0] vout, input bit busy, input bit ovf);
    vec_t v;
    v = '{rst, stb, key, rdy, disp, cnt, valid, vout, busy, ovf};
    tv.push_back(v);
  endtask

  initial begin
    // reset with strobes and ready active
    add(0, 1, 4'h5, 1, 16'h0000, 0, 0, 16'h0000, 0, 0);
    add(0, 1, 4'hA, 0, 16'h0000, 0, 0, 16'h0000, 0, 0);
    // entry and commit
    add(1, 1, 4'h1, 0, 16'h0001, 1, 0, 16'h0000, 0, 0);
    add(1, 1, 4'h2, 0, 16'h0012, 2, 0, 16'h0000, 0, 0);
    add(1, 1, 4'h3, 0, 16'h0123, 3, 0, 16'h0000, 0, 0);
    add(1, 1, 4'hA, 0, 16'h0123, 3, 1, 16'h0123, 1, 0);
    add(1, 0, 4'h0, 0, 16'h0123, 3, 1, 16'h0123, 1, 0);
    add(1, 0, 4'h0, 1, 16'h0000, 0, 0, 16'h0123, 0, 0);
    // overflow
    add(1, 1, 4'h9, 0, 16'h0009, 1, 0, 16'h0123, 0, 0);
    add(1, 1, 4'h8, 0, 16'h0098, 2, 0, 16'h0123, 0, 0);
    add(1, 1, 4'h7, 0, 16'h0987, 3, 0, 16'h0123, 0, 0);
    add(1, 1, 4'h6, 0, 16'h9876, 4, 0, 16'h0123, 0, 0);
    add(1, 1, 4'h5, 0, 16'h9876, 4, 0, 16'h0123, 0, 1);
    add(1, 0, 4'h0, 0, 16'h9876, 4, 0, 16'h0123, 0, 0);
    add(1, 1, 4'hC, 0, 16'h0000, 0, 0, 16'h0123, 0, 0);
    // edit keys
    add(1, 1, 4'h4, 0, 16'h0004, 1, 0, 16'h0123, 0, 0);
    add(1, 1, 4'h5, 0, 16'h0045, 2, 0, 16'h0123, 0, 0);
    add(1, 1, 4'hB, 0, 16'h0004, 1, 0, 16'h0123, 0, 0);
    add(1, 1, 4'hB, 0, 16'h0000, 0, 0, 16'h0123, 0, 0);
    add(1, 1, 4'hA, 0, 16'h0000, 0, 0, 16'h0123, 0, 0);
    add(1, 1, 4'hB, 0, 16'h0000, 0, 0, 16'h0123, 0, 0);
    add(1, 1, 4'h7, 0, 16'h0007, 1, 0, 16'h0123, 0, 0);
    add(1, 1, 4'hE, 0, 16'h0007, 1, 0, 16'h0123, 0, 0);
    add(1, 1, 4'hC, 0, 16'h0000, 0, 0, 16'h0123, 0, 0);
    // hold: strobes dropped, including on the ready edge
    add(1, 1, 4'h2, 0, 16'h0002, 1, 0, 16'h0123, 0, 0);
    add(1, 1, 4'hA, 0, 16'h0002, 1, 1, 16'h0002, 1, 0);
    add(1, 1, 4'h3, 0, 16'h0002, 1, 1, 16'h0002, 1, 0);
    add(1, 1, 4'hC, 0, 16'h0002, 1, 1, 16'h0002, 1, 0);
    add(1, 1, 4'h7, 1, 16'h0000, 0, 0, 16'h0002, 0, 0);
    add(1, 0, 4'h0, 1, 16'h0000, 0, 0, 16'h0002, 0, 0);

    foreach (tv[i]) begin
      step(tv[i].rst, tv[i].stb, tv[i].key, tv[i].rdy);
      chk($sformatf("tv%0d_display", i), 32'(DISPLAY_BCD), 32'(tv[i].disp));
      chk($sformatf("tv%0d_count", i),   32'(DIGIT_COUNT), 32'(tv[i].cnt));
      chk($sformatf("tv%0d_valid", i),   32'(VALUE_VALID), 32'(tv[i].valid));
      chk($sformatf("tv%0d_value", i),   32'(VALUE_OUT),   32'(tv[i].vout));
      chk($sformatf("tv%0d_busy", i),    32'(KEY_BUSY),    32'(tv[i].busy));
      chk($sformatf("tv%0d_ovf", i),     32'(OVF_ERR),     32'(tv[i].ovf));
      chk($sformatf("tv%0d_timeout", i), 32'(TIMEOUT),     32'h0);
    end

`ifdef ENTRY_TIMEOUT_EN
    // timeout after T idle cycles in entry
    step(0, 0, 4'h0, 0);
    step(1, 1, 4'h5, 0);
    for (int i = 1; i < T; i++) begin
      step(1, 0, 4'h0, 0);
      chk("to_early", 32'(TIMEOUT), 32'h0);
    end
    step(1, 0, 4'h0, 0);
    chk("to_pulse", 32'(TIMEOUT), 32'h1);
    chk("to_count", 32'(DIGIT_COUNT), 32'h0);
    step(1, 0, 4'h0, 0);
    chk("to_one_cycle", 32'(TIMEOUT), 32'h0);
    // strobe at idle cycle 15 restarts the timer
    step(1, 1, 4'h5, 0);
    for (int i = 1; i < T - 1; i++) step(1, 0, 4'h0, 0);
    step(1, 1, 4'hE, 0);
    chk("to_restart_none", 32'(TIMEOUT), 32'h0);
    for (int i = 1; i < T; i++) begin
      step(1, 0, 4'h0, 0);
      chk("to_restart_early", 32'(TIMEOUT), 32'h0);
    end
    step(1, 0, 4'h0, 0);
    chk("to_restart_pulse", 32'(TIMEOUT), 32'h1);
`endif

    // randomized run against the model
    step(0, 0, 4'h0, 0);
    for (int i = 0; i < 800; i++) begin
      bit         r_rst;
      bit         r_stb;
      bit         r_rdy;
      logic [3:0] r_key;
      r_rst = ($urandom_range(0, 99) != 0);
      r_stb = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) < 6) r_key = 4'($urandom_range(0, 9));
      else r_key = 4'($urandom_range(10, 15));
      r_rdy = ($urandom_range(0, 3) == 0);
      step(r_rst, r_stb, r_key, r_rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
